// File: rtl/twos_comp_arbiter.sv
// Two-requester round-robin arbiter feeding a registered two's complement unit.
// A conversion takes IDLE -> CAPT (grant) -> CALC (result) -> IDLE.
module twos_comp_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_src,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        CALC = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic             ptr;
    logic             src;
    logic             winner;
    logic             accept;
    logic [WIDTH-1:0] operand;

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        accept    = 1'b0;
        // Pointer only breaks ties; a lone requester always wins.
        if (req0 && req1) winner = ptr;
        else              winner = req1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    accept    = 1'b1;
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                gnt0      = ~src;
                gnt1      = src;
                state_nxt = CALC;
            end
            CALC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            src        <= 1'b0;
            operand    <= '0;
            dout       <= '0;
            dout_src   <= 1'b0;
            ovf        <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            dout_valid <= 1'b0;
            if (accept) begin
                src     <= winner;
                ptr     <= ~winner;
                operand <= winner ? din1 : din0;
            end
            if (state == CALC) begin
                dout       <= ~operand + WIDTH'(1);
                dout_src   <= src;
                ovf        <= (operand == MOST_NEG);
                dout_valid <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_twos_comp_arbiter.sv
// Directed self-checking bench for twos_comp_arbiter (WIDTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_twos_comp_arbiter;

    logic       clk;
    logic       reset_n;
    logic       req0;
    logic [3:0] din0;
    logic       req1;
    logic [3:0] din1;
    logic       gnt0;
    logic       gnt1;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_src;
    logic       ovf;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    twos_comp_arbiter #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0       (req0),
        .din0       (din0),
        .req1       (req1),
        .din1       (din1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_src   (dout_src),
        .ovf        (ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; din0 = '0; din1 = '0;
        tick(); tick();
        n_checks++; if ({gnt0, gnt1, dout_valid, busy} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctrl: gnt0/gnt1/valid/busy=%b required 0000", {gnt0, gnt1, dout_valid, busy}); end
        n_checks++; if ({dout, dout_src, ovf} !== 6'b0) begin n_fail++;
            $display("FAIL reset_data: dout=%b src=%b ovf=%b required 0000 0 0", dout, dout_src, ovf); end
    endtask

    // Request raised on the first edge after reset release; din changed once granted.
    task automatic test_single();
        reset_n = 1'b1; req0 = 1'b1; din0 = 4'b0011;
        tick();
        n_checks++; if ({gnt0, gnt1, busy} !== 3'b101) begin n_fail++;
            $display("FAIL single_gnt: gnt0/gnt1/busy=%b required 101", {gnt0, gnt1, busy}); end
        req0 = 1'b0; din0 = 4'b1010;
        tick();
        n_checks++; if ({gnt0, dout_valid} !== 2'b00) begin n_fail++;
            $display("FAIL single_calc: gnt0/valid=%b required 00", {gnt0, dout_valid}); end
        tick();
        n_checks++; if ({dout_valid, dout, dout_src, ovf, busy} !== 8'b1_1101_0_0_0) begin n_fail++;
            $display("FAIL single_result: valid=%b dout=%b src=%b ovf=%b busy=%b required 1 1101 0 0 0",
                     dout_valid, dout, dout_src, ovf, busy); end
        tick();
        n_checks++; if ({dout_valid, dout} !== 5'b0_1101) begin n_fail++;
            $display("FAIL single_hold: valid=%b dout=%b required 0 1101", dout_valid, dout); end
    endtask

    task automatic test_sweep();
        logic [3:0] expd;
        for (int x = 0; x < 16; x++) begin
            expd = 4'(16 - x);
            req1 = 1'b1; din1 = 4'(x);
            tick();
            n_checks++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++;
                $display("FAIL sweep_gnt x=%0d: gnt0/gnt1=%b required 01", x, {gnt0, gnt1}); end
            req1 = 1'b0;
            tick(); tick();
            n_checks++; if ({dout_valid, dout, dout_src, ovf} !== {1'b1, expd, 1'b1, (x == 8)}) begin n_fail++;
                $display("FAIL sweep_result x=%0d: valid=%b dout=%b src=%b ovf=%b required 1 %b 1 %b",
                         x, dout_valid, dout, dout_src, ovf, expd, (x == 8)); end
        end
    endtask

    task automatic test_simultaneous();
        reset_n = 1'b0; tick();
        reset_n = 1'b1; req0 = 1'b1; req1 = 1'b1; din0 = 4'b0001; din1 = 4'b0010;
        tick();
        n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++;
            $display("FAIL simul_first_gnt: gnt0/gnt1=%b required 10", {gnt0, gnt1}); end
        req0 = 1'b0;
        tick(); tick();
        n_checks++; if ({dout_valid, dout, dout_src} !== 6'b1_1111_0) begin n_fail++;
            $display("FAIL simul_first_result: valid=%b dout=%b src=%b required 1 1111 0", dout_valid, dout, dout_src); end
        tick();
        n_checks++; if ({gnt0, gnt1} !== 2'b01) begin n_fail++;
            $display("FAIL simul_second_gnt: gnt0/gnt1=%b required 01", {gnt0, gnt1}); end
        req1 = 1'b0;
        tick(); tick();
        n_checks++; if ({dout_valid, dout, dout_src} !== 6'b1_1110_1) begin n_fail++;
            $display("FAIL simul_second_result: valid=%b dout=%b src=%b required 1 1110 1", dout_valid, dout, dout_src); end
    endtask

    task automatic test_fairness();
        logic       who;
        logic [3:0] expd;
        reset_n = 1'b0; tick();
        reset_n = 1'b1; req0 = 1'b1; req1 = 1'b1; din0 = 4'b0101; din1 = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            who  = 1'(i % 2);
            expd = who ? 4'b1010 : 4'b1011;
            tick();
            n_checks++; if ({gnt0, gnt1} !== {~who, who}) begin n_fail++;
                $display("FAIL fair_gnt i=%0d: gnt0/gnt1=%b required %b", i, {gnt0, gnt1}, {~who, who}); end
            tick(); tick();
            n_checks++; if ({dout_valid, dout, dout_src} !== {1'b1, expd, who}) begin n_fail++;
                $display("FAIL fair_result i=%0d: valid=%b dout=%b src=%b required 1 %b %b",
                         i, dout_valid, dout, dout_src, expd, who); end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; din0 = 4'b0111;
        tick();
        req0 = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++;
            $display("FAIL midrst_busy: busy=%b required 1", busy); end
        reset_n = 1'b0;
        tick();
        n_checks++; if ({gnt0, gnt1, dout_valid, dout, dout_src, ovf, busy} !== 10'b0) begin n_fail++;
            $display("FAIL midrst_outputs: gnt0=%b gnt1=%b valid=%b dout=%b src=%b ovf=%b busy=%b required all 0",
                     gnt0, gnt1, dout_valid, dout, dout_src, ovf, busy); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++;
            $display("FAIL midrst_no_valid: valid=%b required 0", dout_valid); end
        req0 = 1'b1; req1 = 1'b1; din0 = 4'b0100; din1 = 4'b1001;
        tick();
        n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++;
            $display("FAIL midrst_ptr: gnt0/gnt1=%b required 10", {gnt0, gnt1}); end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();
        n_checks++; if ({dout_valid, dout, dout_src} !== 6'b1_1100_0) begin n_fail++;
            $display("FAIL midrst_result: valid=%b dout=%b src=%b required 1 1100 0", dout_valid, dout, dout_src); end
    endtask

    task automatic test_dropped();
        int seen_gnt1 = 0;
        int seen_valid = 0;
        req0 = 1'b1; din0 = 4'b0010;
        tick();
        n_checks++; if (gnt0 !== 1'b1) begin n_fail++;
            $display("FAIL drop_gnt0: gnt0=%b required 1", gnt0); end
        req0 = 1'b0; req1 = 1'b1; din1 = 4'b0101;
        tick();
        if (gnt1) seen_gnt1++;
        req1 = 1'b0;
        tick();
        n_checks++; if ({dout_valid, dout, dout_src} !== 6'b1_1110_0) begin n_fail++;
            $display("FAIL drop_result: valid=%b dout=%b src=%b required 1 1110 0", dout_valid, dout, dout_src); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gnt1) seen_gnt1++;
            if (dout_valid) seen_valid++;
        end
        n_checks++; if (seen_gnt1 !== 0 || seen_valid !== 0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL drop_ignored: gnt1 pulses=%0d extra valids=%0d busy=%b required 0 0 0",
                     seen_gnt1, seen_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_simultaneous();
        test_fairness();
        test_reset_mid();
        test_dropped();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/twos_comp_arbiter.md
TWOS_COMP_ARBITER -- requirements
Module: twos_comp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of each operand and result.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port req0  input  1  requester 0 conversion request, level, held until gnt0.
REQ-005 SHALL have port din0  input  WIDTH  requester 0 operand, valid while req0 high.
REQ-006 SHALL have port req1  input  1  requester 1 conversion request, level, held until gnt1.
REQ-007 SHALL have port din1  input  WIDTH  requester 1 operand, valid while req1 high.
REQ-008 SHALL have port gnt0  output  1  one-cycle pulse; din0 captured.
REQ-009 SHALL have port gnt1  output  1  one-cycle pulse; din1 captured.
REQ-010 SHALL have port dout  output  WIDTH  registered two's complement of captured operand.
REQ-011 SHALL have port dout_valid  output  1  one-cycle pulse; dout, dout_src, ovf valid.
REQ-012 SHALL have port dout_src  output  1  requester that owns current dout (0 or 1).
REQ-013 SHALL have port ovf  output  1  captured operand was most-negative value (MSB 1, rest 0).
REQ-014 SHALL have port busy  output  1  high when FSM not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CAPT, CALC, held in a registered state variable.
REQ-016 SHALL, in IDLE with any req high at a rising edge, select a winner, latch its din and id, and move to CAPT.
REQ-017 SHALL, in IDLE with no req high, stay in IDLE; gnt0/gnt1/dout_valid low.
REQ-018 SHALL pulse gnt of the winner for exactly the one cycle spent in CAPT; the other gnt stays low.
REQ-019 SHALL go CAPT -> CALC unconditionally; in CALC register dout = (~operand + 1) truncated to WIDTH, set dout_src and ovf, and pulse dout_valid in the following cycle.
REQ-020 SHALL go CALC -> IDLE unconditionally; one conversion takes 3 cycles from the sampling edge, max throughput 1 per 3 cycles.
REQ-021 SHALL hold dout, dout_src, ovf stable after dout_valid until next result is written.
REQ-022 SHALL arbitrate round-robin: 1-bit priority pointer, 0 after reset; on simultaneous requests pointer holder wins.
REQ-023 SHALL set pointer to the non-winning requester after every grant, including single-request grants.
REQ-024 SHALL give a lone request the grant regardless of the pointer.
REQ-025 SHALL ignore req changes and din changes while busy; a req dropped before its grant is not served and leaves no state.
REQ-026 SHALL produce dout = 0, ovf = 0 for operand 0.
REQ-027 SHALL produce dout = operand, ovf = 1 for operand 1000 (WIDTH=4); no saturation.
REQ-028 SHALL re-grant the same requester on its next request if the other requester is idle (no starvation, no forced alternation).

Reset
REQ-029 SHALL, with reset_n low at a rising edge, force state IDLE, pointer 0, gnt0 = gnt1 = 0, dout_valid = 0, dout = 0, dout_src = 0, ovf = 0, busy = 0.
REQ-030 SHALL abort any conversion in CAPT or CALC on reset; no dout_valid is produced for it.
REQ-031 SHALL take reset priority over all other state transitions in the same cycle.
REQ-032 SHALL accept a request on the first rising edge with reset_n high.

Verification
REQ-033 SHALL verify single request: req0=1, din0=0011 -> gnt0 pulse next cycle, dout_valid 2 cycles later, dout=1101, dout_src=0, ovf=0.
REQ-034 SHALL verify full sweep: each operand 0..15 on req1 -> dout = (16-x) mod 16, ovf only for 1000, dout_src=1, matching combinational reference.
REQ-035 SHALL verify simultaneous requests after reset: req0=req1=1, din0=0001, din1=0010 -> gnt0 first with dout=1111, then gnt1 with dout=1110, dout_src 0 then 1.
REQ-036 SHALL verify fairness: both requests held continuously for 6 conversions -> grants alternate 0,1,0,1,0,1, no gap beyond 3 cycles per result.
REQ-037 SHALL verify reset mid-operation: reset_n low during CALC -> no dout_valid, all outputs zero, next simultaneous request grants requester 0.
REQ-038 SHALL verify dropped request: req1 raised and lowered while busy serving requester 0 -> no gnt1, no extra dout_valid.
